// File: rtl/aes3_tx.sv
// AES3/SPDIF transmitter: buffers one 24-bit stereo pair, builds 32-slot subframes
// and biphase-mark encodes them onto one line. Uses X/Y/Z preambles and 192-frame blocks.
module aes3_tx #(
  parameter int CLK_DIV   = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] sample_l,
  input  logic [23:0] sample_r,
  input  logic        in_v,
  input  logic        in_u,
  input  logic        in_c,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        aes3,
  output logic        bsync,
  output logic        lrck,
  output logic        underrun
);

  // Preamble patterns, bit i = level of UI i before polarity correction.
  localparam logic [7:0] PRE_Z = 8'b0001_0111;
  localparam logic [7:0] PRE_X = 8'b0100_0111;
  localparam logic [7:0] PRE_Y = 8'b0010_0111;

  // Slots 4..31 packed LSB-first: audio[23:0], V, U, C, even parity.
  function automatic logic [27:0] make_word(input logic [23:0] audio,
                                            input logic v, input logic u, input logic c);
    logic [26:0] d;
    d = {c, u, v, audio};
    return {^d, d};
  endfunction

  localparam logic [27:0] UNDER_WORD = 28'h9000000;

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [5:0]  ui_q, ui_d;
  logic        sub_b_q, sub_b_d;
  logic [7:0]  frame_q, frame_d;
  logic        full_q, full_d;
  logic [23:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [2:0]  buf_vuc_q, buf_vuc_d;
  logic [27:0] a_q, a_d, b_q, b_d;
  logic        level_q, level_d;
  logic        pol_q, pol_d;
  logic        bsync_q, bsync_d;
  logic        lrck_q, lrck_d;
  logic        underrun_q, underrun_d;

  logic       tick, load, accept, pol_now, cur_bit;
  logic [7:0] pre_pat;
  logic [27:0] load_word_a, load_word_b;

  assign tick    = (div_q == DIV_WIDTH'(CLK_DIV - 1));
  assign load    = tick && (ui_q == 6'd0) && !sub_b_q;
  assign accept  = in_valid && !full_q;
  assign pol_now = (ui_q == 6'd0) ? level_q : pol_q;
  assign cur_bit = sub_b_q ? b_q[0] : a_q[0];
  assign pre_pat = sub_b_q ? PRE_Y : ((frame_q == 8'd0) ? PRE_Z : PRE_X);

  assign load_word_a = full_q ? make_word(buf_l_q, buf_vuc_q[0], buf_vuc_q[1], buf_vuc_q[2])
                              : UNDER_WORD;
  assign load_word_b = full_q ? make_word(buf_r_q, buf_vuc_q[0], buf_vuc_q[1], buf_vuc_q[2])
                              : UNDER_WORD;

  always_comb begin
    // NOTE: every next-state signal is defaulted first so no latch can be inferred.
    div_d      = tick ? '0 : div_q + DIV_WIDTH'(1);
    ui_d       = ui_q;
    sub_b_d    = sub_b_q;
    frame_d    = frame_q;
    full_d     = accept || (full_q && !load);
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    buf_vuc_d  = buf_vuc_q;
    a_d        = a_q;
    b_d        = b_q;
    level_d    = level_q;
    pol_d      = pol_q;
    bsync_d    = bsync_q;
    lrck_d     = lrck_q;
    underrun_d = load && !full_q;

    if (accept) begin
      buf_l_d   = sample_l;
      buf_r_d   = sample_r;
      buf_vuc_d = {in_c, in_u, in_v};
    end

    if (tick) begin
      ui_d = ui_q + 6'd1;
      if (ui_q == 6'd63) begin
        sub_b_d = !sub_b_q;
        if (sub_b_q) frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
      end

      // Preamble UIs carry raw levels; data UIs toggle at slot start, again for a 1.
      if (ui_q < 6'd8)      level_d = pre_pat[ui_q[2:0]] ^ pol_now;
      else if (!ui_q[0])    level_d = !level_q;
      else                  level_d = level_q ^ cur_bit;

      if (ui_q == 6'd0) begin
        pol_d   = level_q;
        lrck_d  = !sub_b_q;
        bsync_d = (frame_q == 8'd0);
      end

      if (ui_q[0] && ui_q >= 6'd9) begin
        if (sub_b_q) b_d = b_q >> 1;
        else         a_d = a_q >> 1;
      end
    end

    if (load) begin
      a_d = load_word_a;
      b_d = load_word_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the data registers are reset too, so the line restarts cleanly on reset.
    if (!reset) begin
      div_q      <= '0;
      ui_q       <= '0;
      sub_b_q    <= 1'b0;
      frame_q    <= '0;
      full_q     <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      buf_vuc_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      level_q    <= 1'b0;
      pol_q      <= 1'b0;
      bsync_q    <= 1'b0;
      lrck_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      div_q      <= div_d;
      ui_q       <= ui_d;
      sub_b_q    <= sub_b_d;
      frame_q    <= frame_d;
      full_q     <= full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      buf_vuc_q  <= buf_vuc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      level_q    <= level_d;
      pol_q      <= pol_d;
      bsync_q    <= bsync_d;
      lrck_q     <= lrck_d;
      underrun_q <= underrun_d;
    end
  end

  assign aes3     = level_q;
  assign in_ready = !full_q;
  assign bsync    = bsync_q;
  assign lrck     = lrck_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_aes3_tx.sv
// Bench for aes3_tx: a frame-level model queues expected subframes, and a line
// monitor decodes the biphase-mark stream and compares each subframe against the queue.
module tb_aes3_tx;

  localparam int CLK_DIV = 2;
  localparam int UI_PER_FRAME = 128;

  localparam logic [0:7] PAT_Z = 8'b11101000;
  localparam logic [0:7] PAT_X = 8'b11100010;
  localparam logic [0:7] PAT_Y = 8'b11100100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] sample_l = '0, sample_r = '0;
  logic        in_v = 1'b0, in_u = 1'b0, in_c = 1'b0, in_valid = 1'b0;
  logic        in_ready, aes3, bsync, lrck, underrun;

  aes3_tx #(.CLK_DIV(CLK_DIV), .DIV_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .sample_l(sample_l), .sample_r(sample_r),
    .in_v(in_v), .in_u(in_u), .in_c(in_c),
    .in_valid(in_valid), .in_ready(in_ready),
    .aes3(aes3), .bsync(bsync), .lrck(lrck), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] audio;
    logic        v, u, c;
    int          frame;
    bit          is_b;
  } sub_t;

  sub_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model state, advanced once per clock edge after reset release.
  int          edge_cnt = 0;
  int          loads = 0;
  int          last_load_edge = -10;
  int          acc_total = 0;
  int          acc_since_load = 0;
  int          cont_loads = 0;
  bit          cont_mode = 0;
  logic        m_full = 1'b0;
  logic        m_under = 1'b0;
  logic [23:0] m_l, m_r;
  logic        m_v, m_u, m_c;

  // Frame f starts on tick 1+128f; tick k lands on clock edge CLK_DIV*k.
  function automatic bit is_load_edge(input int e);
    return e > 0 && (e % CLK_DIV) == 0 && ((e / CLK_DIV - 1) % UI_PER_FRAME) == 0;
  endfunction

  initial begin
    bit acc;
    int f;
    forever begin
      @(posedge clk);
      if (!reset) begin
        edge_cnt = 0; loads = 0; last_load_edge = -10;
        acc_since_load = 0; cont_loads = 0;
        m_full = 1'b0; m_under = 1'b0;
        exp_q.delete();
      end else begin
        edge_cnt++;
        acc = in_valid && !m_full;
        if (is_load_edge(edge_cnt)) begin
          f = loads % 192;
          if (m_full) begin
            exp_q.push_back('{audio: m_l, v: m_v, u: m_u, c: m_c, frame: f, is_b: 1'b0});
            exp_q.push_back('{audio: m_r, v: m_v, u: m_u, c: m_c, frame: f, is_b: 1'b1});
          end else begin
            exp_q.push_back('{audio: 24'd0, v: 1'b1, u: 1'b0, c: 1'b0, frame: f, is_b: 1'b0});
            exp_q.push_back('{audio: 24'd0, v: 1'b1, u: 1'b0, c: 1'b0, frame: f, is_b: 1'b1});
          end
          m_under = !m_full;
          m_full  = 1'b0;
          if (cont_mode) begin
            cont_loads++;
            if (cont_loads >= 2) check("accepts_per_frame", acc_since_load, 1);
          end
          acc_since_load = 0;
          loads++;
          last_load_edge = edge_cnt;
        end
        if (acc) begin
          m_l = sample_l; m_r = sample_r;
          m_v = in_v; m_u = in_u; m_c = in_c;
          m_full = 1'b1;
          acc_total++;
          acc_since_load++;
        end
      end
    end
  end

  // Line monitor: samples each UI level, decodes whole subframes, pops the scoreboard.
  int n_sub = 0;
  initial begin
    logic [0:63] uis;
    logic [0:7]  pat;
    logic [27:0] w;
    logic        prev_level, fl_lrck, fl_bsync;
    int          pos, err;
    sub_t        e;
    prev_level = 1'b0; fl_lrck = 1'b0; fl_bsync = 1'b0; uis = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_level = 1'b0;
        n_sub = 0;
      end else begin
        if (edge_cnt == last_load_edge) begin
          check("underrun_at_load", underrun, m_under);
          check("in_ready_after_load", in_ready, !m_full);
        end else if (edge_cnt == last_load_edge + 1) begin
          check("underrun_one_clk", underrun, 0);
        end
        if (edge_cnt > 0 && (edge_cnt % CLK_DIV) == 0) begin
          pos = (edge_cnt / CLK_DIV - 1) % 64;
          uis[pos] = aes3;
          if (pos == 0) begin
            fl_lrck  = lrck;
            fl_bsync = bsync;
          end
          if (pos == 63) begin
            if (exp_q.size() == 0) begin
              check("scoreboard_entry", 0, 1);
            end else begin
              e = exp_q.pop_front();
              pat = e.is_b ? PAT_Y : ((e.frame == 0) ? PAT_Z : PAT_X);
              check("preamble", uis[0:7], pat ^ {8{prev_level}});
              err = 0;
              for (int k = 4; k < 32; k++) begin
                if (uis[2*k] == uis[2*k-1]) err++;
                w[k-4] = uis[2*k] ^ uis[2*k+1];
              end
              check("bmc_slot_toggle", err, 0);
              check("audio", w[23:0], e.audio);
              check("vuc", w[26:24], {e.c, e.u, e.v});
              check("parity", w[27], ^{e.c, e.u, e.v, e.audio});
              check("lrck", fl_lrck, !e.is_b);
              check("bsync", fl_bsync, e.frame == 0);
              check("end_level", uis[63], 0);
            end
            prev_level = uis[63];
            n_sub++;
          end
        end
      end
    end
  end

  task automatic wait_loads(input int n);
    for (int i = 0; i < 200000 && loads < n; i++) @(negedge clk);
    check("wait_loads_reached", loads >= n, 1);
  endtask

  task automatic randomize_pair();
    sample_l = 24'($urandom);
    sample_r = 24'($urandom);
    in_v = 1'($urandom);
    in_u = 1'($urandom);
    in_c = 1'($urandom);
  endtask

  initial begin
    int prev_acc;
    int guard;

    repeat (5) @(posedge clk);
    #1;
    check("reset_aes3", aes3, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_bsync", bsync, 0);
    check("reset_lrck", lrck, 0);
    check("reset_underrun", underrun, 0);

    @(negedge clk) reset = 1'b1;
    for (guard = 0; guard < 100 && edge_cnt < CLK_DIV - 1; guard++) @(negedge clk);
    check("aes3_before_first_tick", aes3, 0);
    @(negedge clk);
    check("aes3_first_ui", aes3, 1);

    // Directed pair lands in frame 1; frame 0 has already underrun.
    sample_l = 24'h000001; sample_r = 24'h800000;
    in_v = 1'b0; in_u = 1'b0; in_c = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("directed_accept", acc_total, 1);
    in_valid = 1'b0;

    wait_loads(5);

    // Offer a pair on the very edge that loads an empty buffer.
    for (guard = 0; guard < 1000 && ((edge_cnt + 1) % (CLK_DIV * UI_PER_FRAME)) != CLK_DIV; guard++)
      @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    prev_acc = acc_total;
    randomize_pair();
    in_valid = 1'b1;
    @(negedge clk);
    check("late_offer_accepted", acc_total, prev_acc + 1);
    check("late_offer_underrun", underrun, 1);
    in_valid = 1'b0;
    wait_loads(loads + 2);

    // Continuous supply through the block wrap at frame 192.
    cont_mode = 1;
    prev_acc = acc_total;
    randomize_pair();
    in_valid = 1'b1;
    for (guard = 0; guard < 80000 && loads < 194; guard++) begin
      @(negedge clk);
      if (acc_total != prev_acc) begin
        prev_acc = acc_total;
        randomize_pair();
      end
    end
    check("continuous_reached_wrap", loads >= 194, 1);
    cont_mode = 0;
    in_valid = 1'b0;
    wait_loads(loads + 1);

    // Asynchronous reset in the middle of a subframe.
    for (guard = 0; guard < 1000 && ((edge_cnt / CLK_DIV - 1) % 64) != 20; guard++)
      @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset_aes3", aes3, 0);
    check("midreset_bsync", bsync, 0);
    check("midreset_lrck", lrck, 0);
    check("midreset_underrun", underrun, 0);
    check("midreset_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (guard = 0; guard < 100 && edge_cnt < CLK_DIV + 1; guard++) @(negedge clk);
    randomize_pair();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_loads(3);
    check("subframes_after_reset", n_sub >= 4, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d loads", loads);
    $fatal(1, "watchdog");
  end

endmodule
